// File: rtl/serial_add_sub_pkg.sv
// Shared types for the slice-serial adder/subtractor: FSM state encoding and
// the index-width helper.
package serial_add_sub_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Slice index width; a single-slice configuration still needs a 1-bit index.
  function automatic int idx_w(input int nsl);
    return (nsl > 1) ? $clog2(nsl) : 1;
  endfunction

endpackage

// File: rtl/add_slice.sv
// Combinational SLICE-bit ripple adder built from per-bit full-adder cells.
// c_msb exposes the carry into the top bit so the caller can derive overflow.
module add_slice #(
  parameter int SLICE = 4
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic             cin,
  output logic [SLICE-1:0] s,
  output logic             cout,
  output logic             c_msb
);

  logic [SLICE:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < SLICE; i++) begin : g_fa
    assign s[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign cout  = c[SLICE];
  assign c_msb = c[SLICE-1];

endmodule

// File: rtl/serial_add_sub.sv
// Multi-cycle add/subtract: processes SLICE bits per clock, LSB slice first,
// with a start/busy/done handshake and results held until the next start.
module serial_add_sub
  import serial_add_sub_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SLICE = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             op_sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int NSL = WIDTH / SLICE;
  localparam int IW  = idx_w(NSL);
  localparam logic [IW-1:0] LAST = IW'(NSL - 1);

  state_t                        state;
  logic [NSL-1:0][SLICE-1:0]     a_r, b_r, sum_r;
  logic                          carry;
  logic [IW-1:0]                 idx;

  logic [SLICE-1:0]              s_sl;
  logic                          c_sl, c_msb;

  add_slice #(.SLICE(SLICE)) u_slice (
    .a     (a_r[idx]),
    .b     (b_r[idx]),
    .cin   (carry),
    .s     (s_sl),
    .cout  (c_sl),
    .c_msb (c_msb)
  );

  assign sum = sum_r;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      a_r      <= '0;
      b_r      <= '0;
      sum_r    <= '0;
      carry    <= 1'b0;
      idx      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      cout     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          done <= 1'b0;
          if (start) begin
            // Subtraction runs as a + ~b + ~cin through the same adder.
            a_r   <= a;
            b_r   <= op_sub ? ~b : b;
            carry <= cin ^ op_sub;
            idx   <= '0;
            sum_r <= '0;
            busy  <= 1'b1;
            state <= S_RUN;
          end else begin
            state <= S_IDLE;
          end
        end
        S_RUN: begin
          sum_r[idx] <= s_sl;
          carry      <= c_sl;
          if (idx == LAST) begin
            cout     <= c_sl;
            overflow <= c_sl ^ c_msb;
            busy     <= 1'b0;
            done     <= 1'b1;
            state    <= S_DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_sub.sv
// Directed bench for serial_add_sub: a 16/4 instance driven from a vector
// table plus handshake corner sequences, and a 4/4 single-slice instance.
module tb_serial_add_sub;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // 16-bit, 4 slices
  logic        start16 = 0, op16 = 0, cin16 = 0;
  logic [15:0] a16 = '0, b16 = '0;
  logic        busy16, done16, cout16, ovf16;
  logic [15:0] sum16;

  // 4-bit, single slice
  logic        start4 = 0, op4 = 0, cin4 = 0;
  logic [3:0]  a4 = '0, b4 = '0;
  logic        busy4, done4, cout4, ovf4;
  logic [3:0]  sum4;

  serial_add_sub #(.WIDTH(16), .SLICE(4)) dut16 (
    .clock(clk), .reset(rst), .start(start16), .op_sub(op16), .a(a16), .b(b16),
    .cin(cin16), .busy(busy16), .done(done16), .sum(sum16), .cout(cout16),
    .overflow(ovf16)
  );

  serial_add_sub #(.WIDTH(4), .SLICE(4)) dut4 (
    .clock(clk), .reset(rst), .start(start4), .op_sub(op4), .a(a4), .b(b4),
    .cin(cin4), .busy(busy4), .done(done4), .sum(sum4), .cout(cout4),
    .overflow(ovf4)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  typedef struct {
    logic        op;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [15:0] esum;
    logic        ecout;
    logic        eovf;
  } vec_t;

  // Runs one op on dut16 with start pulsed for one cycle. Returns the
  // accept-to-done latency (0 on timeout) and the number of busy cycles.
  task automatic run16(input logic op, input logic [15:0] a, input logic [15:0] b,
                       input logic cin, output int lat, output int bcnt);
    @(negedge clk);
    op16 = op; a16 = a; b16 = b; cin16 = cin; start16 = 1'b1;
    @(posedge clk); #1;
    start16 = 1'b0;
    bcnt = busy16 ? 1 : 0;
    lat  = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (busy16) bcnt++;
      if (done16) begin
        lat = i;
        break;
      end
    end
  endtask

  vec_t vecs[9];
  int   lat, bcnt, npulse;

  initial begin
    vecs[0] = '{1'b0, 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[2] = '{1'b0, 16'h7FFF, 16'h0000, 1'b1, 16'h8000, 1'b0, 1'b1};
    vecs[3] = '{1'b1, 16'h0005, 16'h0007, 1'b0, 16'hFFFE, 1'b0, 1'b0};
    vecs[4] = '{1'b1, 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b1, 1'b1};
    vecs[5] = '{1'b0, 16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
    vecs[6] = '{1'b1, 16'h1234, 16'h1234, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[7] = '{1'b1, 16'h0000, 16'h0000, 1'b1, 16'hFFFF, 1'b0, 1'b0};
    vecs[8] = '{1'b1, 16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b0, 1'b1};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy16, 0);
    chk("rst_done", done16, 0);
    chk("rst_sum",  sum16, 0);
    chk("rst_cout", cout16, 0);
    chk("rst_ovf",  ovf16, 0);
    @(negedge clk) rst = 1'b0;

    // Vector table
    foreach (vecs[i]) begin
      run16(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].cin, lat, bcnt);
      chk($sformatf("v%0d_latency", i), lat, 4);
      chk($sformatf("v%0d_busycyc", i), bcnt, 4);
      chk($sformatf("v%0d_sum", i),  sum16, vecs[i].esum);
      chk($sformatf("v%0d_cout", i), cout16, vecs[i].ecout);
      chk($sformatf("v%0d_ovf", i),  ovf16, vecs[i].eovf);
      @(posedge clk); #1;
      chk($sformatf("v%0d_done_1cyc", i), done16, 0);
      chk($sformatf("v%0d_sum_hold", i), sum16, vecs[i].esum);
    end

    // Start re-pulsed during RUN is ignored
    @(negedge clk);
    op16 = 0; a16 = 16'h1234; b16 = 16'h4321; cin16 = 0; start16 = 1;
    @(posedge clk); #1;                          // accept edge k
    start16 = 0;
    @(posedge clk); #1;                          // k+1
    start16 = 1; op16 = 1; a16 = 16'hAAAA; b16 = 16'h0F0F; cin16 = 1;
    @(posedge clk); #1;                          // k+2
    @(posedge clk); #1;                          // k+3
    start16 = 0;
    npulse = 0;
    lat = 0;
    for (int i = 4; i <= 12; i++) begin
      @(posedge clk); #1;
      if (done16) begin
        npulse++;
        if (lat == 0) begin
          lat = i;
          chk("rerun_sum", sum16, 16'h5555);
          chk("rerun_cout", cout16, 0);
        end
      end
    end
    chk("rerun_latency", lat, 4);
    chk("rerun_pulses", npulse, 1);
    chk("rerun_sum_held", sum16, 16'h5555);

    // Reset during the 2nd RUN cycle aborts immediately
    run16(1'b0, 16'h8000, 16'h8000, 1'b0, lat, bcnt);
    chk("pre_abort_cout", cout16, 1);
    chk("pre_abort_ovf",  ovf16, 1);
    @(negedge clk);
    a16 = 16'h1111; b16 = 16'h2222; op16 = 0; cin16 = 0; start16 = 1;
    @(posedge clk); #1;
    start16 = 0;
    @(posedge clk); #1;
    chk("abort_busy_before", busy16, 1);
    rst = 1'b1;
    #1;
    chk("abort_busy", busy16, 0);
    chk("abort_done", done16, 0);
    chk("abort_sum",  sum16, 0);
    chk("abort_cout", cout16, 0);
    chk("abort_ovf",  ovf16, 0);
    @(negedge clk) rst = 1'b0;
    npulse = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (done16) npulse++;
    end
    chk("abort_no_done", npulse, 0);
    run16(1'b0, 16'h0001, 16'h0001, 1'b0, lat, bcnt);
    chk("after_abort_lat", lat, 4);
    chk("after_abort_sum", sum16, 16'h0002);

    // Start held through DONE: back-to-back with no idle cycle
    @(negedge clk);
    op16 = 0; a16 = 16'h1234; b16 = 16'h4321; cin16 = 0; start16 = 1;
    @(posedge clk); #1;                          // accept k
    op16 = 1; a16 = 16'h0005; b16 = 16'h0007; cin16 = 0;
    repeat (4) @(posedge clk);
    #1;                                          // k+4
    chk("b2b_done1", done16, 1);
    chk("b2b_sum1", sum16, 16'h5555);
    @(posedge clk); #1;                          // k+5
    chk("b2b_busy_noidle", busy16, 1);
    chk("b2b_done_low", done16, 0);
    start16 = 0;
    repeat (3) @(posedge clk);
    #1;                                          // k+8
    chk("b2b_not_yet", done16, 0);
    @(posedge clk); #1;                          // k+9
    chk("b2b_done2", done16, 1);
    chk("b2b_sum2", sum16, 16'hFFFE);
    chk("b2b_cout2", cout16, 0);

    // Single-slice instance, start held for back-to-back ops
    @(negedge clk);
    op4 = 0; a4 = 4'h9; b4 = 4'h8; cin4 = 0; start4 = 1;
    @(posedge clk); #1;                          // accept k
    chk("w4_busy", busy4, 1);
    a4 = 4'h3; b4 = 4'h4;
    @(posedge clk); #1;                          // k+1
    chk("w4_done1", done4, 1);
    chk("w4_sum1", sum4, 4'h1);
    chk("w4_cout1", cout4, 1);
    chk("w4_ovf1", ovf4, 1);
    @(posedge clk); #1;                          // k+2
    chk("w4_busy2", busy4, 1);
    chk("w4_done_low", done4, 0);
    start4 = 0;
    @(posedge clk); #1;                          // k+3
    chk("w4_done2", done4, 1);
    chk("w4_sum2", sum4, 4'h7);
    chk("w4_cout2", cout4, 0);
    chk("w4_ovf2", ovf4, 0);
    @(posedge clk); #1;
    chk("w4_idle", busy4 | done4, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
